// File: rtl/output_menu_sel.sv
// Button-driven channel selector: synchronises and debounces two menu buttons and
// steps a registered index over CHANNELS packed sources. Define OUTPUT_MENU_SEL_REPEAT_EN for hold-to-repeat.
module output_menu_sel #(
  parameter int  WIDTH           = 24,
  parameter int  CHANNELS        = 8,
  parameter int  DEBOUNCE_CYCLES = 4,
  parameter int  REPEAT_CYCLES   = 1000,
  localparam int SW              = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                button,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          out,
  output logic [SW-1:0]             sel,
  output logic                      sel_changed
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] LAST    = SW'(CHANNELS - 1);

  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          db_q, db_d;
  logic [1:0]          db_prev_q;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                chg_q, chg_d;

  logic rise_next, rise_prev;
  logic rep_next, rep_prev;
  logic step_next, step_prev;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == db_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == DB_LAST) begin
        db_d[b]  = sync2_q[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  // A press only counts while the other button is released.
  assign rise_next = db_q[0] & ~db_prev_q[0] & ~db_q[1];
  assign rise_prev = db_q[1] & ~db_prev_q[1] & ~db_q[0];

`ifdef OUTPUT_MENU_SEL_REPEAT_EN
  localparam int            RW       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_act_q, rep_act_d;
  logic          rep_dir_q, rep_dir_d;   // 1: repeating "previous"
  logic          rep_held;

  assign rep_held = rep_dir_q ? (db_q == 2'b10) : (db_q == 2'b01);

  // Armed by an accepted step; any change of the debounced pair disarms it.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_act_d = rep_act_q;
    rep_dir_d = rep_dir_q;
    rep_next  = 1'b0;
    rep_prev  = 1'b0;
    if (rise_next || rise_prev) begin
      rep_act_d = 1'b1;
      rep_dir_d = rise_prev;
      rep_cnt_d = '0;
    end else if (rep_act_q && rep_held) begin
      if (rep_cnt_q == REP_LAST) begin
        rep_cnt_d = '0;
        rep_next  = ~rep_dir_q;
        rep_prev  = rep_dir_q;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end else begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_act_q <= 1'b0;
      rep_dir_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_act_q <= rep_act_d;
      rep_dir_q <= rep_dir_d;
    end
  end
`else
  // Hold-to-repeat is compiled out; the repeat period has no effect in this build.
  assign rep_next = 1'b0 & (REPEAT_CYCLES > 0);
  assign rep_prev = 1'b0;
`endif

  assign step_next = rise_next | rep_next;
  assign step_prev = rise_prev | rep_prev;

  always_comb begin
    sel_d = sel_q;
    if (step_next) begin
      sel_d = (sel_q == LAST) ? '0 : sel_q + 1'b1;
    end else if (step_prev) begin
      sel_d = (sel_q == '0) ? LAST : sel_q - 1'b1;
    end
    chg_d = step_next | step_prev;
    // The registered index drives the mux, so out trails a step by one cycle.
    out_d = in_bus[int'(sel_q)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      out_q     <= '0;
      chg_q     <= 1'b0;
    end else begin
      sync1_q   <= button;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      out_q     <= out_d;
      chg_q     <= chg_d;
    end
  end

  assign out         = out_q;
  assign sel         = sel_q;
  assign sel_changed = chg_q;

endmodule

// File: tb/tb_output_menu_sel.sv
// Self-checking bench for output_menu_sel: an 8-channel and a 5-channel instance share
// clock, reset and buttons; expected steps are queued when presses are driven.
module tb_output_menu_sel;

  localparam int WIDTH = 24;
  localparam int DB    = 4;
  localparam int REP   = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         button;
  logic [8*WIDTH-1:0] bus8;
  logic [5*WIDTH-1:0] bus5;
  logic [WIDTH-1:0]   out8, out5;
  logic [2:0]         sel8, sel5;
  logic               chg8, chg5;

  output_menu_sel #(.WIDTH(WIDTH), .CHANNELS(8), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(REP)) dut8 (
    .clk(clk), .rst(rst), .button(button), .in_bus(bus8),
    .out(out8), .sel(sel8), .sel_changed(chg8)
  );

  output_menu_sel #(.WIDTH(WIDTH), .CHANNELS(5), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(REP)) dut5 (
    .clk(clk), .rst(rst), .button(button), .in_bus(bus5),
    .out(out5), .sel(sel5), .sel_changed(chg5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s8;
    logic [2:0] s5;
    int         at_edge;
    string      name;
  } exp_t;

  typedef struct {
    string      name;
    bit         pre_reset;
    logic [1:0] btn;
    int         hi;
    int         lo;
    int         dir;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         exp8   = 0;
  int         exp5   = 0;
  bit         mon_en = 1'b0;
  bit         out_pend = 1'b0;
  logic [WIDTH-1:0] exp_o8, exp_o5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_step(input int dir, input int at_edge, input string name);
    exp_t e;
    exp8 = (exp8 + dir + 8) % 8;
    exp5 = (exp5 + dir + 5) % 5;
    e.s8 = 3'(exp8);
    e.s5 = 3'(exp5);
    e.at_edge = at_edge;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp8 = 0;
    exp5 = 0;
    @(negedge clk);
    check("reset_sel8", sel8, 0);
    check("reset_sel5", sel5, 0);
  endtask

  task automatic finish_seq(input string name);
    check({name, "_pending"}, sb.size(), 0);
    sb.delete();
    check({name, "_sel8"}, sel8, exp8);
    check({name, "_sel5"}, sel5, exp5);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.pre_reset) do_reset();
    if (v.dir != 0) push_step(v.dir, cyc + 1 + DB + 2, v.name);
    button = v.btn;
    repeat (v.hi) @(negedge clk);
    button = 2'b00;
    repeat (v.lo) @(negedge clk);
    finish_seq(v.name);
  endtask

  // Edge counter: cyc is the index of the most recent rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard consumer: every sel_changed pulse pops one expected step.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("chg_agree", chg5, chg8);
      check("sel5_range", sel5 < 3'd5, 1);
      if (out_pend) begin
        check("out8_after_step", out8, exp_o8);
        check("out5_after_step", out5, exp_o5);
        check("pulse_width", chg8, 0);
        out_pend = 1'b0;
      end else if (chg8) begin
        if (sb.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_step_edge"}, cyc, e.at_edge);
          check({e.name, "_step_sel8"}, sel8, e.s8);
          check({e.name, "_step_sel5"}, sel5, e.s5);
          exp_o8 = 24'h000100 + 24'(e.s8);
          exp_o5 = 24'h000100 + 24'(e.s5);
          out_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) bus8[k*WIDTH +: WIDTH] = 24'h000100 + 24'(k);
    for (int k = 0; k < 5; k++) bus5[k*WIDTH +: WIDTH] = 24'h000100 + 24'(k);
    rst    = 1'b1;
    button = 2'b00;

    for (int i = 0; i < 8; i++) vecs[i] = '{"next", 1'b0, 2'b01, 10, 10, 1};
    vecs[8]  = '{"prev_wrap", 1'b1, 2'b10, 10, 10, -1};
    vecs[9]  = '{"glitch3",   1'b0, 2'b01, 3,  10, 0};
    vecs[10] = '{"both",      1'b0, 2'b11, 10, 10, 0};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out8", out8, 0);
      check("rst_sel8", sel8, 0);
      check("rst_chg8", chg8, 0);
      check("rst_out5", out5, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out8", out8, 24'h000100);
    check("post_rst_out5", out5, 24'h000100);
    mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Previous pressed while next is held: only the next press steps.
    push_step(1, cyc + 1 + DB + 2, "hold_next");
    button = 2'b01;
    repeat (8) @(negedge clk);
    button = 2'b11;
    repeat (10) @(negedge clk);
    button = 2'b01;
    repeat (10) @(negedge clk);
    button = 2'b00;
    repeat (10) @(negedge clk);
    finish_seq("prev_while_next");

    // Reset two edges into a press discards it; the held button re-debounces.
    do_reset();
    push_step(1, cyc + 1 + 9, "rst_mid");
    button = 2'b01;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    button = 2'b00;
    repeat (12) @(negedge clk);
    finish_seq("rst_mid");

    // Long hold: one step, plus repeats every REP clocks when enabled.
    do_reset();
    begin
      int t;
      t = cyc + 1;
      push_step(1, t + DB + 2, "hold");
`ifdef OUTPUT_MENU_SEL_REPEAT_EN
      push_step(1, t + DB + 2 + REP,     "repeat1");
      push_step(1, t + DB + 2 + 2 * REP, "repeat2");
      push_step(1, t + DB + 2 + 3 * REP, "repeat3");
`endif
    end
    button = 2'b01;
    repeat (40) @(negedge clk);
    button = 2'b00;
    repeat (15) @(negedge clk);
    finish_seq("hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_menu_sel.md
# output_menu_sel

Parametrised button-driven output selector: picks one of `CHANNELS` packed `WIDTH`-bit sources and drives it, registered, to the display/output path. Generalises the fixed 8×24-bit `output_menu`. Adds:
- on-chip synchronisation and debouncing of the two raw menu buttons;
- wrap-around stepping for any channel count;
- a selection-change strobe;
- optional hold-to-repeat stepping.

## Interface
Parameters:
- `WIDTH`, 24, bits per channel.
- `CHANNELS`, 8, number of sources; ≥2, need not be a power of 2.
- `DEBOUNCE_CYCLES`, 4, consecutive stable synchronised samples required to accept a button level; ≥1.
- `REPEAT_CYCLES`, 1000, auto-repeat period in clocks; ≥1; used only with `OUTPUT_MENU_SEL_REPEAT_EN`.

Ports (SW = max(1, $clog2(CHANNELS))):
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `button`  in  2  raw, asynchronous; bit0 = next, bit1 = previous.
- `in_bus`  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- `out`  out  WIDTH  registered selected channel.
- `sel`  out  SW  current channel index.
- `sel_changed`  out  1  one-cycle pulse on the edge where `sel` takes a new value.

## Operation
- Reset state: `sync1`, `sync2`, `db`, `db_d` = 0; debounce counters = 0; `sel` = 0; `out` = 0; `sel_changed` = 0; repeat counters = 0.
- Synchroniser: each bit passes through a two-flop synchroniser, `sync1` then `sync2`.
- Debounce, per bit, independent:
  - If `sync2 == db`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` with the mismatch still present, `db <= sync2` and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge detect: `db_d <= db`.
  - `rise0 = db[0] & ~db_d[0] & ~db[1]`
  - `rise1 = db[1] & ~db_d[1] & ~db[0]`
  - Both buttons rising in the same cycle, or one rising while the other is held: no step.
- Stepping:
  - `rise0`: `sel <= (sel == CHANNELS-1) ? 0 : sel+1`.
  - `rise1`: `sel <= (sel == 0) ? CHANNELS-1 : sel-1`.
  - `sel_changed` is asserted on the same edge that `sel` updates.
  - `sel` never holds a value ≥ `CHANNELS`.
- Output: `out <= in_bus[sel*WIDTH +: WIDTH]` every cycle.
  - `out` follows changes on the live input with one cycle of latency.
  - `out` uses the registered `sel`, never the next-state value.
- Reset mid-operation: every counter and register returns to its reset value on the next edge. A partially debounced press is discarded. A button already held when `rst` falls must pass the full debounce before it can produce a step.

## Timing
- Button goes high and stays stable, first sampled at edge t:
  - `sync2` = 1 at t+1
  - `db` = 1 at t+DEBOUNCE_CYCLES+1
  - `sel` and `sel_changed` update at t+DEBOUNCE_CYCLES+2
  - `out` shows the new channel at t+DEBOUNCE_CYCLES+3
- Release follows the same debounce latency and produces no step.
- Glitch rejection: a raw pulse shorter than `DEBOUNCE_CYCLES` cycles at `sync2` never changes `db`.
- Steady state: at most one step per `DEBOUNCE_CYCLES` + 1 cycles without repeat.
- `sel_changed` is high for exactly one cycle per step.

## Configuration
- Macro: `OUTPUT_MENU_SEL_REPEAT_EN`.
- Defined: while exactly one debounced button stays held, a repeat counter starts at the initial step.
  - Further steps in the same direction follow every `REPEAT_CYCLES` clocks: initial step at edge s, repeats at s+R, s+2R, …
  - Each repeat asserts `sel_changed` and wraps like a normal step.
  - The counter clears on release, when the other button is pressed, or on `rst`.
- Undefined: holding a button produces exactly one step. No repeat counter is synthesised and `REPEAT_CYCLES` is ignored.

## Test plan
Bench settings: WIDTH=24, CHANNELS=8, DEBOUNCE_CYCLES=4, in channel k = 24'h000100+k.

- Reset check: hold `rst` 3 cycles → `out`=0, `sel`=0, `sel_changed`=0 throughout. First edge after `rst` falls → `out`=24'h000100.
- Wrap forward: 8 clean next presses (10 cycles high, 10 low) → `sel` goes 1,2,…,7,0. `out` = 24'h000101…24'h000107, then 24'h000100. Each change is marked by one `sel_changed` pulse, with `sel` updating 6 edges after press onset.
- Wrap backward: at `sel`=0, one prev press → `sel`=7, `out`=24'h000107. Repeat with CHANNELS=5 → `sel`=4 and never reaches 5–7.
- Glitch and simultaneity:
  - next high for 3 cycles → no change.
  - both buttons pressed on the same cycle → no change and no `sel_changed`.
  - prev pressed while next is held → no change.
- Reset mid-debounce: next rises, `rst` pulses 1 cycle two edges later, button still held → `sel` stays 0 for 6 edges after `rst` falls, then steps to 1.
- Repeat, with macro defined and REPEAT_CYCLES=10: hold next for 40 cycles after the initial step → `sel` = 1, 2, 3, 4 at steps s, s+10, s+20, s+30; stops on release. Without the macro, the same stimulus gives `sel`=1 only.
